// File: rtl/neureka_accumulator_buffer_ctrl.sv
// Accumulator buffer sequencer: clear, multi-pass wide read-modify-write accumulation,
// then a one-word-per-cycle valid/ready streamout of the accumulated words.

module neureka_acc_lane #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_acc,
  input  logic [DATA_WIDTH-1:0] i_psum,
  output logic [DATA_WIDTH-1:0] o_sum
);
  // Per-word wrap-around add; lanes never carry into each other.
  assign o_sum = i_acc + i_psum;
endmodule

module neureka_accumulator_buffer_ctrl #(
  parameter  int unsigned DATA_WIDTH   = 32,
  parameter  int unsigned NUM_WORDS    = 32,
  parameter  int unsigned WIDTH_FACTOR = 8,
  localparam int unsigned ADDR_WIDTH   = $clog2(NUM_WORDS)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               start_i,
  input  logic                               abort_i,
  input  logic [7:0]                         n_passes_i,
  input  logic [ADDR_WIDTH:0]                n_words_i,
  input  logic                               psum_valid_i,
  output logic                               psum_ready_o,
  input  logic [WIDTH_FACTOR*DATA_WIDTH-1:0] psum_data_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [DATA_WIDTH-1:0]              out_data_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               buf_clear_o,
  output logic                               buf_we_wide_o,
  output logic [NUM_WORDS-1:0]               buf_wmask_o,
  output logic [WIDTH_FACTOR*DATA_WIDTH-1:0] buf_wdata_wide_o,
  output logic [ADDR_WIDTH-1:0]              buf_raddr_o,
  input  logic [DATA_WIDTH-1:0]              buf_rdata_i,
  input  logic [WIDTH_FACTOR*DATA_WIDTH-1:0] buf_rdata_wide_i
);
  localparam int unsigned BEATS  = NUM_WORDS / WIDTH_FACTOR;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned WIDE_W = WIDTH_FACTOR * DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] NW_MAX = (ADDR_WIDTH+1)'(NUM_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_STREAM, S_DONE} state_e;

  state_e                r_state, w_next;
  logic [BEAT_W-1:0]     r_beat;
  logic [7:0]            r_pass, r_npasses;
  logic [ADDR_WIDTH:0]   r_nwords, r_word;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [WIDE_W-1:0]     w_sum;
  logic                  w_beat_acc, w_last_beat, w_last_pass, w_load, w_out_hs, w_final_hs;

  assign w_beat_acc  = (r_state == S_ACCUM) && psum_valid_i && !abort_i;
  assign w_last_beat = (r_beat == BEAT_W'(BEATS-1));
  assign w_last_pass = (r_pass == r_npasses - 8'd1);
  assign w_load      = (r_state == S_STREAM) && (!r_out_valid || out_ready_i) && (r_word < r_nwords);
  assign w_out_hs    = r_out_valid && out_ready_i;
  // All words are loaded once r_word reaches n_words, so this handshake is the last one.
  assign w_final_hs  = (r_state == S_STREAM) && w_out_hs && (r_word == r_nwords);

  for (genvar j = 0; j < WIDTH_FACTOR; j++) begin : g_lane
    neureka_acc_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .i_acc  (buf_rdata_wide_i[j*DATA_WIDTH +: DATA_WIDTH]),
      .i_psum (psum_data_i[j*DATA_WIDTH +: DATA_WIDTH]),
      .o_sum  (w_sum[j*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next           = r_state;
    psum_ready_o     = 1'b0;
    buf_clear_o      = 1'b0;
    buf_we_wide_o    = w_beat_acc;
    buf_wmask_o      = '0;
    buf_wdata_wide_o = '0;
    buf_raddr_o      = '0;
    unique case (r_state)
      S_IDLE:  if (start_i) w_next = S_CLEAR;
      S_CLEAR: begin
        buf_clear_o = 1'b1;
        w_next      = S_ACCUM;
      end
      S_ACCUM: begin
        psum_ready_o = 1'b1;
        buf_raddr_o  = ADDR_WIDTH'({r_beat, 1'b0});
        if (w_beat_acc) begin
          buf_wdata_wide_o = w_sum;
          for (int g = 0; g < BEATS; g++)
            if (r_beat == BEAT_W'(g)) buf_wmask_o[g*WIDTH_FACTOR +: WIDTH_FACTOR] = '1;
          if (w_last_beat && w_last_pass) w_next = S_STREAM;
        end
      end
      S_STREAM: begin
        buf_raddr_o = r_word[ADDR_WIDTH-1:0];
        if (w_final_hs) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort_i) w_next = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_beat      <= '0;
      r_pass      <= '0;
      r_npasses   <= '0;
      r_nwords    <= '0;
      r_word      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (abort_i) begin
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (start_i) begin
          r_npasses <= (n_passes_i == 8'd0) ? 8'd1 : n_passes_i;
          r_nwords  <= (n_words_i == '0 || n_words_i > NW_MAX) ? NW_MAX : n_words_i;
          r_beat    <= '0;
          r_pass    <= '0;
          r_word    <= '0;
        end
        S_ACCUM: if (w_beat_acc) begin
          r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
          if (w_last_beat) begin
            r_pass <= r_pass + 8'd1;
            if (w_last_pass) r_word <= '0;
          end
        end
        S_STREAM: begin
          if (w_load) begin
            r_out_data  <= buf_rdata_i;
            r_out_valid <= 1'b1;
            r_word      <= r_word + 1'b1;
          end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = (r_state == S_DONE);

endmodule

// File: doc/neureka_accumulator_buffer_ctrl.md
# neureka_accumulator_buffer_ctrl

Sequencer for one accumulator buffer: clears it, runs read-modify-write accumulation of incoming wide partial-sum beats over a programmable number of passes, then streams the accumulated words out one per cycle over a valid/ready interface. It sits between the engine's partial-sum stream and the accumulator buffer. It owns every buffer write and read port during a tile.

## Interface
- DATA_WIDTH, 32, width of one accumulator word
- NUM_WORDS, 32, words in the buffer
- WIDTH_FACTOR, 8, words per wide beat; BEATS = NUM_WORDS/WIDTH_FACTOR (4)
- ADDR_WIDTH, $clog2(NUM_WORDS), derived, not overridable
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  start a tile; sampled only in IDLE
- abort_i  in  1  synchronous abort; returns to IDLE from any state
- n_passes_i  in  8  accumulation passes; sampled at start; 0 treated as 1
- n_words_i  in  ADDR_WIDTH+1  words to stream; sampled at start; 0 or >NUM_WORDS treated as NUM_WORDS
- psum_valid_i / psum_ready_o  in/out  1  partial-sum beat handshake
- psum_data_i  in  WIDTH_FACTOR*DATA_WIDTH  beat; word j in bits [(j+1)*DATA_WIDTH-1 : j*DATA_WIDTH]
- out_valid_o / out_ready_i  out/in  1  streamout handshake
- out_data_o  out  DATA_WIDTH  streamed word
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse at tile completion
- buf_clear_o  out  1  buffer clear
- buf_we_wide_o  out  1  buffer wide write enable
- buf_wmask_o  out  NUM_WORDS  write mask; the group of WIDTH_FACTOR bits for the current beat is set
- buf_wdata_wide_o  out  WIDTH_FACTOR*DATA_WIDTH  wide write data
- buf_raddr_o  out  ADDR_WIDTH  read address
- buf_rdata_i  in  DATA_WIDTH  single-word read data; combinational from buf_raddr_o
- buf_rdata_wide_i  in  WIDTH_FACTOR*DATA_WIDTH  wide read data; combinational from buf_raddr_o

## Operation
- **FSM states:** IDLE, CLEAR, ACCUM, STREAM, DONE.
- **IDLE:**
  - start_i=1 latches n_passes and n_words, clears the beat and pass counters, and moves to CLEAR.
- **CLEAR:**
  - buf_clear_o=1 for exactly one cycle, then ACCUM.
- **ACCUM:**
  - psum_ready_o=1.
  - Beat b = beat counter; buf_raddr_o = 2*b, which is the buffer's aligned wide-read encoding.
  - A beat is accepted when psum_valid_i=1. On acceptance:
    - buf_we_wide_o=1.
    - buf_wmask_o bits [b*WIDTH_FACTOR +: WIDTH_FACTOR] are set.
    - buf_wdata_wide_o word j = buf_rdata_wide_i word j + psum_data_i word j.
  - Addition is per word, modulo 2^DATA_WIDTH (two's-complement wrap, no saturation, no cross-word carry).
  - Beat counter wraps BEATS-1 -> 0 and increments the pass counter.
  - Acceptance of beat BEATS-1 of pass n_passes-1 moves to STREAM and clears the word counter.
  - Beats never arrive out of order; the controller does not reorder them.
- **STREAM:**
  - psum_ready_o=0 and buf_raddr_o = word counter w.
  - Output register loads buf_rdata_i and sets out_valid_o when (out_valid_o=0 or out_ready_i=1) and w < n_words; w then increments.
  - out_valid_o clears on handshake when no further word is loaded.
  - When the word with index n_words-1 completes its handshake, move to DONE.
- **DONE:**
  - done_o=1 for one cycle, then IDLE.
  - Buffer contents are left intact.
- **Idle outputs:** in every state not listed above, all buf_* enables are 0.
- **start_i while busy:** ignored.
- **abort_i:**
  - Has priority over every transition.
  - Next cycle the state is IDLE and out_valid_o=0.
  - done_o is not pulsed.
  - No buffer write occurs in the abort cycle, even if a psum handshake coincides.

## Timing
- **Reset values:** state IDLE, all counters 0, out_valid_o=0, out_data_o=0, done_o=0, busy_o=0; psum_ready_o=0 and all buf_* outputs 0.
- **Start:** start_i at cycle 0 -> buf_clear_o at cycle 1 -> psum_ready_o from cycle 2.
- **ACCUM throughput:** 1 beat/cycle. The write lands at the next edge, so back-to-back passes on the same beat read updated data.
- **Entry into STREAM:** the last write lands at the edge entering STREAM. The first out_valid_o is one cycle after STREAM entry.
- **STREAM throughput:** 1 word/cycle with out_ready_i held high. out_valid_o/out_data_o are held stable while out_ready_i=0.
- **Done:** done_o one cycle after the final output handshake.
- **Tile length:** with no stalls, a tile takes 2 + BEATS*n_passes + n_words + 2 cycles from start.

## Test plan
- **Single pass:** n_passes=1, n_words=32, beats carry word value = global index k (0..31), ready high -> out_data sequence 0..31, done_o exactly one cycle after the last handshake.
- **Three passes:** each beat word = k+1 -> out word k = 3*(k+1); psum_ready_o low in CLEAR and STREAM.
- **Wrap:** DATA_WIDTH=32, two passes of 32'hFFFF_FFFF into word 5 -> out word 5 = 32'hFFFF_FFFE; neighbouring words unaffected.
- **Backpressure:** random out_ready_i at 30% -> no dropped or duplicated words; data stable while stalled. Random psum_valid_i gaps -> identical results.
- **Boundaries:**
  - n_words=0 -> 32 words streamed.
  - n_words=1 -> only word 0 streamed.
  - n_passes=0 behaves as 1.
  - start_i pulsed mid-ACCUM -> ignored.
- **Abort mid-STREAM:** abort_i after 10 words -> next cycle IDLE, out_valid_o=0, no done_o. A subsequent tile starts cleanly, with buffer cleared in CLEAR.
